// File: rtl/sram_arb_ctrl.sv
// Asynchronous-SRAM controller: arbitrates independent write/read request
// channels and sequences CS#/WE#/OE# with a programmable access width.
//
// state     | meaning
// IDLE      | bus released, strobes inactive, requests sampled
// WR_SETUP  | CS# low, address and data driven, WE# high
// WR_PULSE  | WE# low for WAIT cycles
// WR_HOLD   | WE# high, data still driven so the SRAM latches it cleanly
// RD_ACCESS | CS#/OE# low for WAIT+1 cycles, data captured on the last edge
// TURN      | OE# high, bus idle, rdata presented with rvalid
module sram_arb_ctrl #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 8,
  parameter int WAIT     = 2,
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sram_wreq,
  input  logic [ADDR_W-1:0] sram_waddr,
  input  logic [DATA_W-1:0] sram_wdata,
  output logic              sram_wack,
  input  logic              sram_rreq,
  input  logic [ADDR_W-1:0] sram_raddr,
  output logic              sram_rack,
  output logic [DATA_W-1:0] sram_rdata,
  output logic              sram_rvalid,
  output logic              busy,
  output logic              sram_cs_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data
);

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ACCESS, TURN
  } state_t;

  localparam logic [3:0] CNT_RD = 4'(WAIT);
  localparam logic [3:0] CNT_WR = 4'(WAIT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_rd_q, last_rd_d;
  logic              grant_w, grant_r;
  logic              tc;
  logic              drive_q;
  logic [DATA_W-1:0] wdata_q;

  assign tc = (cnt_q == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      last_rd_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_rd_q <= last_rd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_rd_d = last_rd_q;
    grant_w   = 1'b0;
    grant_r   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // last_rd_q doubles as the round-robin pointer: write wins after a read
        if (sram_wreq && (!sram_rreq || ARB_MODE == 1 || last_rd_q)) grant_w = 1'b1;
        else if (sram_rreq) grant_r = 1'b1;
        if (grant_w) begin
          state_d   = WR_SETUP;
          last_rd_d = 1'b0;
        end
        if (grant_r) begin
          state_d   = RD_ACCESS;
          cnt_d     = CNT_RD;
          last_rd_d = 1'b1;
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = CNT_WR;
      end
      WR_PULSE: begin
        if (tc) state_d = WR_HOLD;
        else    cnt_d   = cnt_q - 4'd1;
      end
      WR_HOLD: state_d = IDLE;
      RD_ACCESS: begin
        if (tc) state_d = TURN;
        else    cnt_d   = cnt_q - 4'd1;
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin outputs are registered from the next state so strobes cannot glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_cs_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      drive_q     <= 1'b0;
      sram_wack   <= 1'b0;
      sram_rack   <= 1'b0;
      sram_rvalid <= 1'b0;
      busy        <= 1'b0;
      sram_addr   <= '0;
      wdata_q     <= '0;
      sram_rdata  <= '0;
    end else begin
      sram_cs_n   <= (state_d == IDLE) || (state_d == TURN);
      sram_we_n   <= (state_d != WR_PULSE);
      sram_oe_n   <= (state_d != RD_ACCESS);
      drive_q     <= (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
      sram_wack   <= grant_w;
      sram_rack   <= grant_r;
      sram_rvalid <= (state_q == RD_ACCESS) && tc;
      busy        <= (state_d != IDLE);
      if (grant_w) begin
        sram_addr <= sram_waddr;
        wdata_q   <= sram_wdata;
      end else if (grant_r) begin
        sram_addr <= sram_raddr;
      end
      if ((state_q == RD_ACCESS) && tc) sram_rdata <= sram_data;
    end
  end

  assign sram_data = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: doc/sram_arb_ctrl.md
Name: sram_arb_ctrl

Overview:
- Parametrised asynchronous-SRAM controller. It replaces the fixed 15-bit-address / 8-bit-data controller used under the PLL-driven test harness.
- It accepts independent write and read request channels and arbitrates between them in one of two modes.
- It sequences CS#/WE#/OE# with a programmable access width and drives or releases the bidirectional data bus, with a guaranteed turnaround cycle.
- It sits between the test/traffic generator and the SRAM pins, in the 50 MHz PLL clock domain.

Parameters:
- ADDR_W, 15, SRAM address width.
- DATA_W, 8, SRAM data width.
- WAIT, 2, WE# low-pulse length and read access length minus one, in clk cycles. Legal range is 1..15.
- ARB_MODE, 0, 0 = round-robin between write and read, 1 = fixed write priority.

Ports:
- clk  in  1  system clock (PLL output)
- rst  in  1  synchronous reset, active high
- sram_wreq  in  1  write request; held with address/data until sram_wack
- sram_waddr  in  ADDR_W  write address
- sram_wdata  in  DATA_W  write data
- sram_wack  out  1  one-cycle pulse: write accepted, address/data latched
- sram_rreq  in  1  read request; held with address until sram_rack
- sram_raddr  in  ADDR_W  read address
- sram_rack  out  1  one-cycle pulse: read accepted
- sram_rdata  out  DATA_W  read data, valid when sram_rvalid is high, held until next read
- sram_rvalid  out  1  one-cycle pulse: sram_rdata updated
- busy  out  1  high whenever the state is not IDLE
- sram_cs_n  out  1  chip select, active low
- sram_we_n  out  1  write enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_addr  out  ADDR_W  SRAM address
- sram_data  inout  DATA_W  SRAM data bus; driven only during write states, otherwise high-Z

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active high.
- Reset values:
  - sram_cs_n, sram_we_n and sram_oe_n are 1.
  - sram_addr is 0 and sram_data is high-Z.
  - sram_wack, sram_rack, sram_rvalid and busy are 0.
  - sram_rdata is 0.
  - The state is IDLE and the round-robin pointer is set so that a write wins first.
- All outputs are registered. Strobes never glitch.
- FSM states: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ACCESS, TURN.
- IDLE:
  - Requests are sampled only in IDLE.
  - With one request pending, it is granted.
  - With both pending: ARB_MODE=1 grants the write. ARB_MODE=0 grants the channel not served last, then flips the pointer.
  - On grant at edge k, the address (and data for a write) is latched, and the matching ack is high during cycle k+1 only.
- Write sequence (accepted at edge k):
  - WR_SETUP, 1 cycle: cs_n=0, addr valid, data driven, we_n=1.
  - WR_PULSE, WAIT cycles: we_n=0.
  - WR_HOLD, 1 cycle: we_n=1, cs_n=0, data still driven.
  - Then IDLE: cs_n=1, bus high-Z.
  - Occupancy is WAIT+2 cycles.
- Read sequence (accepted at edge k):
  - RD_ACCESS, WAIT+1 cycles: cs_n=0, oe_n=0, addr valid, bus high-Z.
  - sram_data is sampled at the last RD_ACCESS edge.
  - TURN, 1 cycle: cs_n=1, oe_n=1, sram_rvalid=1 with the new sram_rdata.
  - Then IDLE. Occupancy is WAIT+2 cycles.
- Bus contention: the data bus is never driven while oe_n=0. At least one cycle with oe_n=1 and the bus high-Z separates any read from a following write.
- Back-to-back: a request already pending when the controller returns to IDLE is granted on that IDLE edge. Throughput is one access per WAIT+3 cycles.
- Requester protocol: the requester must drop req in the cycle it sees ack. A req still high when the controller re-enters IDLE is a new request.
- Request inputs outside IDLE are ignored and never lost: they stay pending as long as they are held.
- Reset mid-operation: on the reset edge, the controller returns to IDLE and all strobes go inactive. The bus is released in the same cycle. A partially completed access gives no ack or rvalid afterwards, and SRAM contents at that address are undefined.
- Widths: sram_addr/sram_waddr/sram_raddr are ADDR_W bits and data is DATA_W bits. No truncation or extension inside the block.

Test Plan:
- Single write, WAIT=2: wreq, waddr=0x1234, wdata=0xA5 at edge 0 -> wack in cycle 1. cs_n low cycles 1-4, we_n low cycles 2-3, sram_data=0xA5 cycles 1-4, then high-Z. busy low at cycle 5.
- Single read, WAIT=2, SRAM model returns 0x5A at 0x1234: rreq at edge 0 -> rack in cycle 1. oe_n low cycles 1-3, rvalid=1 with rdata=0x5A in cycle 4, bus never driven by the DUT.
- Simultaneous requests, ARB_MODE=0, wreq and rreq held continuously -> grants alternate W,R,W,R starting with W, each 5 cycles apart. ARB_MODE=1 -> only writes granted while wreq is held.
- Write-after-read turnaround: read then an immediate write -> at least one cycle with oe_n=1 and the bus high-Z before the DUT drives sram_data. The bench checks no overlap of DUT drive and oe_n=0 in any cycle.
- Parameter sweep ADDR_W=19, DATA_W=16, WAIT=1 and WAIT=15: write 0xBEEF to 0x7FFFF, then read it back -> rdata=0xBEEF. we_n pulse width equals WAIT cycles exactly.
- Reset mid-write: assert rst during WR_PULSE -> next cycle we_n=cs_n=1, bus high-Z, busy=0, no ack/rvalid. A subsequent write-then-read to the same address returns the new data.
